pu_or1k_store_buffer_drain: RTL and testbench
=============================================

Name: pu_or1k_store_buffer_drain

Overview:
Write-back stage downstream of the LSU store buffer FIFO. Pops one buffered store at a time and issues it as a single Wishbone classic write. Resolves atomic (store-conditional) entries against the reservation. Reports bus errors with the faulting PC and address back to the LSU exception logic.

Parameters:
OPTION_OPERAND_WIDTH, 32, address/data width; byte-select width is OPTION_OPERAND_WIDTH/8.
MAX_RETRY, 4, retry attempts before a retried write is treated as an error; used only with the optional feature.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  asynchronous, active-low reset.
sb_empty_i  in  1  store buffer empty.
sb_read_o  out  1  pop strobe; the entry's data is valid on sb_* inputs the cycle after sb_read_o=1.
sb_adr_i  in  OPTION_OPERAND_WIDTH  popped store address.
sb_dat_i  in  OPTION_OPERAND_WIDTH  popped store data.
sb_bsel_i  in  OPTION_OPERAND_WIDTH/8  popped byte selects.
sb_pc_i  in  OPTION_OPERAND_WIDTH  PC of the store instruction.
sb_atomic_i  in  1  entry is a store-conditional.
halt_i  in  1  inhibits new pops (msync, cache maintenance); sampled only in IDLE.
atomic_reserve_i  in  1  reservation still valid.
wbm_adr_o  out  OPTION_OPERAND_WIDTH  bus address.
wbm_dat_o  out  OPTION_OPERAND_WIDTH  bus write data.
wbm_sel_o  out  OPTION_OPERAND_WIDTH/8  bus byte selects.
wbm_we_o, wbm_cyc_o, wbm_stb_o  out  1 each  Wishbone controls.
wbm_cti_o  out  3  constant 3'b000 (classic cycle).
wbm_bte_o  out  2  constant 2'b00.
wbm_ack_i, wbm_err_i, wbm_rty_i  in  1 each  Wishbone terminations.
store_done_o  out  1  one-cycle pulse when a write is acked.
atomic_fail_o  out  1  one-cycle pulse when an atomic entry is discarded.
bus_err_o  out  1  one-cycle pulse on a terminated-with-error write.
err_adr_o, err_pc_o  out  OPTION_OPERAND_WIDTH each  address and PC of the last erroring store; held until the next error.
idle_o  out  1  state is IDLE and sb_empty_i=1 (drain complete).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - sb_read_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, all pulses = 0.
  - wbm_adr_o, wbm_dat_o, wbm_sel_o, err_adr_o, err_pc_o = 0.
  - Asserting reset mid-write drops cyc/stb immediately; the in-flight entry is lost.
- IDLE: if !sb_empty_i && !halt_i, drive sb_read_o=1 (combinational from state) for exactly one cycle and go to LOAD. Otherwise stay.
- LOAD: register sb_adr_i, sb_dat_i, sb_bsel_i, sb_pc_i, sb_atomic_i.
  - If sb_atomic_i && !atomic_reserve_i: pulse atomic_fail_o next cycle, return to IDLE, no bus cycle.
  - Otherwise go to WRITE.
- WRITE: cyc=stb=we=1; adr/dat/sel come from the registered entry and are stable for the whole cycle. Terminations are checked in priority order err > rty > ack:
  - err: go to IDLE, pulse bus_err_o, latch err_adr_o/err_pc_o; the entry is dropped.
  - ack: pulse store_done_o, go to IDLE.
  - rty: see Optional Feature.
- cyc/stb/we are registered outputs and deassert the cycle after termination.
- Throughput: one store per 3 cycles minimum (IDLE→LOAD→WRITE, single-cycle ack).
- No re-pop while an entry is held; sb_read_o is never asserted while sb_empty_i=1.
- halt_i rising during LOAD or WRITE does not abort the current store; it only blocks the next pop.
- idle_o=1 only in IDLE with sb_empty_i=1; an atomic discard or error returns to IDLE as normal.

Optional Feature:
Macro PU_OR1K_SB_DRAIN_RETRY_EN.
- Defined: wbm_rty_i in WRITE moves to RETRY.
  - RETRY drops cyc/stb for one cycle, increments a retry counter of width $clog2(MAX_RETRY+1), then returns to WRITE with the same entry.
  - If the counter already equals MAX_RETRY, rty is handled as err.
  - The counter clears on every entry load.
- Undefined: wbm_rty_i is ignored; WRITE waits for ack or err. No RETRY state and no counter are built.

Test Plan:
- Single store: buffer holds adr=0x0000_1000, dat=0xDEAD_BEEF, bsel=4'hF, ack in the 1st WRITE cycle -> sb_read_o for 1 cycle, cyc/stb/we high for 1 cycle with those values, store_done_o pulse, idle_o=1.
- Back-to-back: 3 entries, ack delayed 2 cycles each -> three writes in FIFO order, exactly 3 sb_read_o pulses, never stb while sb_empty_i=1.
- Atomic fail: entry atomic=1, atomic_reserve_i=0 -> no cyc, atomic_fail_o pulse. Repeat with reserve=1 -> normal write.
- Bus error: err on store pc=0x0000_2004, adr=0x8000_0000 -> bus_err_o pulse, err_pc_o=0x0000_2004, err_adr_o=0x8000_0000, next entry proceeds.
- halt/reset: halt_i=1 with 2 entries -> no pop. Async rst low mid-WRITE -> cyc/stb=0 same cycle, all outputs at reset values.
- With PU_OR1K_SB_DRAIN_RETRY_EN, MAX_RETRY=2: rty, rty, ack -> two 1-cycle cyc gaps then store_done_o. rty×3 -> bus_err_o.

Source files
------------

// File: rtl/pu_or1k_store_buffer_drain.sv
// -----------------------------------------------------------------------------
// pu_or1k_store_buffer_drain
//
// Write-back stage that sits behind the LSU store buffer FIFO. It pops one
// buffered store at a time and issues it as a single Wishbone classic write.
// Store-conditional entries are checked against the reservation. If the
// reservation has been lost, the entry is discarded and no bus cycle is
// started. A write that ends with an error is reported back to the LSU
// exception logic, together with the store's PC and address.
//
// Optional feature (macro PU_OR1K_SB_DRAIN_RETRY_EN):
//   When the macro is defined, wbm_rty_i causes the same entry to be retried.
//   Each retry drops cyc/stb for one cycle before the write is reissued.
//   After MAX_RETRY retries, a further rty is handled as an error.
//   When the macro is undefined, wbm_rty_i is ignored.
//
// Ports:
//   clk, rst             clock (rising edge); asynchronous active-low reset
//   sb_empty_i           store buffer empty
//   sb_read_o            pop strobe; entry valid on sb_*_i the following cycle
//   sb_adr_i/dat_i/bsel_i/pc_i/atomic_i   popped entry fields
//   halt_i               blocks new pops (only looked at in IDLE)
//   atomic_reserve_i     reservation still valid
//   wbm_*                Wishbone classic master (write only)
//   store_done_o         1-cycle pulse after an acked write
//   atomic_fail_o        1-cycle pulse after a discarded store-conditional
//   bus_err_o            1-cycle pulse after an errored write
//   err_adr_o, err_pc_o  address/PC of the last errored store
//   idle_o               IDLE with an empty store buffer
// -----------------------------------------------------------------------------
module pu_or1k_store_buffer_drain #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int MAX_RETRY            = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sb_empty_i,
    output logic                              sb_read_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
    input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
    input  logic                              sb_atomic_i,
    input  logic                              halt_i,
    input  logic                              atomic_reserve_i,
    output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_dat_o,
    output logic [OPTION_OPERAND_WIDTH/8-1:0] wbm_sel_o,
    output logic                              wbm_we_o,
    output logic                              wbm_cyc_o,
    output logic                              wbm_stb_o,
    output logic [2:0]                        wbm_cti_o,
    output logic [1:0]                        wbm_bte_o,
    input  logic                              wbm_ack_i,
    input  logic                              wbm_err_i,
    input  logic                              wbm_rty_i,
    output logic                              store_done_o,
    output logic                              atomic_fail_o,
    output logic                              bus_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   err_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   err_pc_o,
    output logic                              idle_o
);

    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int SW = OPTION_OPERAND_WIDTH / 8;

`ifdef PU_OR1K_SB_DRAIN_RETRY_EN
    localparam int CNT_W = $clog2(MAX_RETRY + 1);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, RETRY} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;
`endif

    state_t         state_q, state_d;
    logic [W-1:0]   adr_q, adr_d;
    logic [W-1:0]   dat_q, dat_d;
    logic [SW-1:0]  sel_q, sel_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [W-1:0]   err_adr_q, err_adr_d;
    logic [W-1:0]   err_pc_q, err_pc_d;
    logic           cyc_q, cyc_d;
    logic           done_q, done_d;
    logic           afail_q, afail_d;
    logic           berr_q, berr_d;
    logic           sb_read;
`ifdef PU_OR1K_SB_DRAIN_RETRY_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // wbm_rty_i and MAX_RETRY only matter when retry support is built in.
    localparam logic [31:0] MAX_RETRY_V = 32'(MAX_RETRY);
    logic unused_ok;
    assign unused_ok = ^{wbm_rty_i, MAX_RETRY_V};
`endif

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        pc_d      = pc_q;
        err_adr_d = err_adr_q;
        err_pc_d  = err_pc_q;
        done_d    = 1'b0;
        afail_d   = 1'b0;
        berr_d    = 1'b0;
        sb_read   = 1'b0;
`ifdef PU_OR1K_SB_DRAIN_RETRY_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!sb_empty_i && !halt_i) begin
                    sb_read = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                adr_d = sb_adr_i;
                dat_d = sb_dat_i;
                sel_d = sb_bsel_i;
                pc_d  = sb_pc_i;
`ifdef PU_OR1K_SB_DRAIN_RETRY_EN
                cnt_d = '0;
`endif
                // A store-conditional that has lost its reservation never reaches the bus.
                if (sb_atomic_i && !atomic_reserve_i) begin
                    afail_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Termination priority: err, then rty, then ack.
                if (wbm_err_i) begin
                    berr_d    = 1'b1;
                    err_adr_d = adr_q;
                    err_pc_d  = pc_q;
                    state_d   = IDLE;
`ifdef PU_OR1K_SB_DRAIN_RETRY_EN
                end else if (wbm_rty_i) begin
                    if (cnt_q == CNT_W'(MAX_RETRY)) begin
                        berr_d    = 1'b1;
                        err_adr_d = adr_q;
                        err_pc_d  = pc_q;
                        state_d   = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = RETRY;
                    end
`endif
                end else if (wbm_ack_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef PU_OR1K_SB_DRAIN_RETRY_EN
            RETRY: begin
                state_d = WRITE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        // cyc/stb/we are high exactly while the FSM sits in WRITE.
        cyc_d = (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            pc_q      <= '0;
            err_adr_q <= '0;
            err_pc_q  <= '0;
            cyc_q     <= 1'b0;
            done_q    <= 1'b0;
            afail_q   <= 1'b0;
            berr_q    <= 1'b0;
`ifdef PU_OR1K_SB_DRAIN_RETRY_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            pc_q      <= pc_d;
            err_adr_q <= err_adr_d;
            err_pc_q  <= err_pc_d;
            cyc_q     <= cyc_d;
            done_q    <= done_d;
            afail_q   <= afail_d;
            berr_q    <= berr_d;
`ifdef PU_OR1K_SB_DRAIN_RETRY_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign sb_read_o     = sb_read;
    assign wbm_adr_o     = adr_q;
    assign wbm_dat_o     = dat_q;
    assign wbm_sel_o     = sel_q;
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = cyc_q;
    assign wbm_we_o      = cyc_q;
    assign wbm_cti_o     = 3'b000;
    assign wbm_bte_o     = 2'b00;
    assign store_done_o  = done_q;
    assign atomic_fail_o = afail_q;
    assign bus_err_o     = berr_q;
    assign err_adr_o     = err_adr_q;
    assign err_pc_o      = err_pc_q;
    assign idle_o        = (state_q == IDLE) && sb_empty_i;

endmodule

// File: tb/tb_pu_or1k_store_buffer_drain.sv
module tb_pu_or1k_store_buffer_drain;

    localparam int W    = 32;
    localparam int SW   = W / 8;
    localparam int MAXR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sb_empty_i, sb_read_o, sb_atomic_i, halt_i, atomic_reserve_i;
    logic [W-1:0]  sb_adr_i, sb_dat_i, sb_pc_i;
    logic [SW-1:0] sb_bsel_i;
    logic [W-1:0]  wbm_adr_o, wbm_dat_o;
    logic [SW-1:0] wbm_sel_o;
    logic          wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]    wbm_cti_o;
    logic [1:0]    wbm_bte_o;
    logic          wbm_ack_i, wbm_err_i, wbm_rty_i;
    logic          store_done_o, atomic_fail_o, bus_err_o, idle_o;
    logic [W-1:0]  err_adr_o, err_pc_o;

    pu_or1k_store_buffer_drain #(.OPTION_OPERAND_WIDTH(W), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst(rst),
        .sb_empty_i(sb_empty_i), .sb_read_o(sb_read_o),
        .sb_adr_i(sb_adr_i), .sb_dat_i(sb_dat_i), .sb_bsel_i(sb_bsel_i),
        .sb_pc_i(sb_pc_i), .sb_atomic_i(sb_atomic_i),
        .halt_i(halt_i), .atomic_reserve_i(atomic_reserve_i),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
        .store_done_o(store_done_o), .atomic_fail_o(atomic_fail_o),
        .bus_err_o(bus_err_o), .err_adr_o(err_adr_o), .err_pc_o(err_pc_o),
        .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  adr;
        logic [W-1:0]  dat;
        logic [W-1:0]  pc;
        logic [SW-1:0] sel;
        logic          atomic;
    } entry_t;

    entry_t       sbq[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           pops_seen = 0;
    int           bad_pops = 0;
    int           m_pops = 0;
    logic [W-1:0] m_err_adr = '0;
    logic [W-1:0] m_err_pc = '0;

    // Independent pop observer: counts strobes and pops requested from an empty buffer.
    always @(negedge clk) begin
        if (rst) begin
            if (sb_read_o) pops_seen++;
            if (sb_read_o && sb_empty_i) bad_pops++;
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic entry_t mk(input logic [W-1:0] adr, input logic [W-1:0] dat,
                                  input logic [SW-1:0] sel, input logic [W-1:0] pc,
                                  input logic atomic);
        entry_t e;
        e.adr = adr; e.dat = dat; e.sel = sel; e.pc = pc; e.atomic = atomic;
        return e;
    endfunction

    function automatic entry_t rnd_entry(input logic atomic);
        return mk($urandom, $urandom, SW'($urandom_range(1, 15)), $urandom, atomic);
    endfunction

    task automatic push(input entry_t e);
        sbq.push_back(e);
        sb_empty_i = 1'b0;
        #1;
    endtask

    task automatic check_bus(input entry_t e);
        chk("bus_cyc", wbm_cyc_o, 1);
        chk("bus_stb", wbm_stb_o, 1);
        chk("bus_we", wbm_we_o, 1);
        chk("bus_adr", wbm_adr_o, e.adr);
        chk("bus_dat", wbm_dat_o, e.dat);
        chk("bus_sel", wbm_sel_o, W'(e.sel));
        chk("bus_cti", W'(wbm_cti_o), 0);
        chk("bus_bte", W'(wbm_bte_o), 0);
    endtask

    // Called at the negedge of an IDLE cycle with a non-empty buffer and halt low.
    // Returns at the negedge of the IDLE cycle that follows the store.
    task automatic process_one(input logic reserve, input int delay, input bit is_err,
                               input int nrty, input bit halt_mid);
        entry_t e;
        bit     done;
        bit     fail_err;
        int     visit;
        chk("idle_pop", sb_read_o, 1);
        chk("idle_nocyc", wbm_cyc_o, 0);
        @(posedge clk); #1;
        e = sbq.pop_front();
        m_pops++;
        sb_adr_i = e.adr; sb_dat_i = e.dat; sb_bsel_i = e.sel;
        sb_pc_i = e.pc; sb_atomic_i = e.atomic;
        sb_empty_i = (sbq.size() == 0);
        atomic_reserve_i = reserve;
        if (halt_mid) halt_i = 1'b1;
        @(negedge clk);
        chk("load_nopop", sb_read_o, 0);
        chk("load_nocyc", wbm_cyc_o, 0);
        @(posedge clk); #1;
        // Entry fields are only valid during LOAD; scramble them afterwards.
        sb_adr_i = $urandom; sb_dat_i = $urandom; sb_pc_i = $urandom;
        sb_bsel_i = SW'($urandom); sb_atomic_i = 1'($urandom);
        if (e.atomic && !reserve) begin
            @(negedge clk);
            chk("afail_pulse", atomic_fail_o, 1);
            chk("afail_nocyc", wbm_cyc_o, 0);
            chk("afail_nodone", store_done_o, 0);
            chk("afail_noerr", bus_err_o, 0);
            return;
        end
        visit = 0; done = 0; fail_err = 0;
        while (!done) begin
            for (int d = 0; d < delay; d++) begin
                wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
`ifdef PU_OR1K_SB_DRAIN_RETRY_EN
                wbm_rty_i = 1'b0;
`else
                wbm_rty_i = 1'($urandom);
`endif
                @(negedge clk); check_bus(e);
                @(posedge clk); #1;
            end
            wbm_rty_i = 1'b0;
`ifdef PU_OR1K_SB_DRAIN_RETRY_EN
            if (visit < nrty) begin
                wbm_rty_i = 1'b1;
                @(negedge clk); check_bus(e);
                @(posedge clk); #1;
                wbm_rty_i = 1'b0;
                if (visit >= MAXR) begin
                    fail_err = 1; done = 1;
                end else begin
                    @(negedge clk);
                    chk("retry_gap_cyc", wbm_cyc_o, 0);
                    chk("retry_gap_stb", wbm_stb_o, 0);
                    @(posedge clk); #1;
                    visit++;
                end
                continue;
            end
`endif
            wbm_err_i = is_err;
            wbm_ack_i = is_err ? 1'($urandom) : 1'b1;
            @(negedge clk); check_bus(e);
            @(posedge clk); #1;
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
            fail_err = is_err; done = 1;
        end
        if (fail_err) begin
            m_err_adr = e.adr;
            m_err_pc  = e.pc;
        end
        @(negedge clk);
        chk("done_pulse", store_done_o, W'(!fail_err));
        chk("berr_pulse", bus_err_o, W'(fail_err));
        chk("afail_none", atomic_fail_o, 0);
        chk("cyc_drop", wbm_cyc_o, 0);
        chk("err_adr", err_adr_o, m_err_adr);
        chk("err_pc", err_pc_o, m_err_pc);
        if (halt_mid) chk("halt_blocks_next", sb_read_o, 0);
    endtask

    initial begin
        int pops_before;
        entry_t e;
        rst = 1'b0; sb_empty_i = 1'b1; halt_i = 1'b0; atomic_reserve_i = 1'b0;
        sb_adr_i = '0; sb_dat_i = '0; sb_pc_i = '0; sb_bsel_i = '0; sb_atomic_i = 1'b0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_we", wbm_we_o, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_dat", wbm_dat_o, 0);
        chk("rst_sel", W'(wbm_sel_o), 0);
        chk("rst_pop", sb_read_o, 0);
        chk("rst_errs", {err_adr_o | err_pc_o}, 0);
        chk("rst_pulses", W'({store_done_o, atomic_fail_o, bus_err_o}), 0);
        chk("rst_idle", idle_o, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("empty_idle", idle_o, 1);
        chk("empty_nopop", sb_read_o, 0);

        // Single store, ack in the first WRITE cycle.
        push(mk(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0000_0100, 1'b0));
        chk("pending_not_idle", idle_o, 0);
        process_one(1'b0, 0, 1'b0, 0, 1'b0);
        chk("single_idle", idle_o, 1);

        // Three back-to-back stores, ack delayed by two cycles each.
        pops_before = pops_seen;
        for (int i = 0; i < 3; i++) push(rnd_entry(1'b0));
        for (int i = 0; i < 3; i++) process_one(1'b0, 2, 1'b0, 0, 1'b0);
        #2;
        chk("b2b_pop_count", W'(pops_seen - pops_before), 3);
        chk("b2b_idle", idle_o, 1);

        // Store-conditional without and then with the reservation.
        push(rnd_entry(1'b1));
        process_one(1'b0, 0, 1'b0, 0, 1'b0);
        push(rnd_entry(1'b1));
        process_one(1'b1, 1, 1'b0, 0, 1'b0);

        // Bus error, then the next entry still goes through.
        push(mk(32'h8000_0000, 32'h1234_5678, 4'h3, 32'h0000_2004, 1'b0));
        push(rnd_entry(1'b0));
        process_one(1'b0, 1, 1'b1, 0, 1'b0);
        chk("err_pc_fixed", err_pc_o, 32'h0000_2004);
        chk("err_adr_fixed", err_adr_o, 32'h8000_0000);
        process_one(1'b0, 0, 1'b0, 0, 1'b0);

        // halt_i blocks pops from IDLE.
        halt_i = 1'b1;
        push(rnd_entry(1'b0));
        push(rnd_entry(1'b0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_nopop", sb_read_o, 0);
            chk("halt_nocyc", wbm_cyc_o, 0);
            chk("halt_not_idle", idle_o, 0);
        end
        halt_i = 1'b0; #1;
        // halt rising during LOAD lets that store finish but blocks the next pop.
        process_one(1'b0, 1, 1'b0, 0, 1'b1);
        halt_i = 1'b0; #1;
        process_one(1'b0, 0, 1'b0, 0, 1'b0);

`ifdef PU_OR1K_SB_DRAIN_RETRY_EN
        // rty, rty, ack -> two gaps then done; rty x3 -> error.
        push(rnd_entry(1'b0));
        push(rnd_entry(1'b0));
        process_one(1'b0, 0, 1'b0, 2, 1'b0);
        process_one(1'b0, 0, 1'b0, 3, 1'b0);
`endif

        // Randomized drain against the reference model.
        for (int i = 0; i < 24; i++) push(rnd_entry(($urandom_range(0, 3) == 0)));
        for (int i = 0; i < 24; i++)
            process_one(1'($urandom), $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                        $urandom_range(0, 3), 1'b0);
        chk("rand_idle", idle_o, 1);

        // Asynchronous reset in the middle of a write.
        push(rnd_entry(1'b0));
        @(posedge clk); #1;
        e = sbq.pop_front();
        m_pops++;
        sb_adr_i = e.adr; sb_dat_i = e.dat; sb_bsel_i = e.sel;
        sb_pc_i = e.pc; sb_atomic_i = e.atomic; sb_empty_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_bus(e);
        #2 rst = 1'b0;
        #1;
        chk("arst_cyc", wbm_cyc_o, 0);
        chk("arst_stb", wbm_stb_o, 0);
        chk("arst_we", wbm_we_o, 0);
        chk("arst_adr", wbm_adr_o, 0);
        chk("arst_dat", wbm_dat_o, 0);
        chk("arst_sel", W'(wbm_sel_o), 0);
        chk("arst_err_adr", err_adr_o, 0);
        chk("arst_err_pc", err_pc_o, 0);
        chk("arst_pulses", W'({store_done_o, atomic_fail_o, bus_err_o}), 0);
        m_err_adr = '0; m_err_pc = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_arst_idle", idle_o, 1);
        chk("post_arst_nocyc", wbm_cyc_o, 0);

        #2;
        chk("pop_total", W'(pops_seen), W'(m_pops));
        chk("no_pop_when_empty", W'(bad_pops), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
